lab2_result_tx: RTL

- Return-path formatter for the Lab2 adder.
- Consumes the adder's 4-bit sum, carry-out and ready pulse, and converts the result into an ASCII line.
- Drives that line byte-by-byte into the UART transmitter using a start/busy handshake.
- Sits between the adder output and the UART TX, the mirror of the RX-side operand path.

---
 rtl/lab2_result_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lab2_result_tx.sv
// Result-line formatter for the Lab2 adder: turns {cout,sum} into "=<c><hex>\r\n" for the UART TX.
// LAB2_RESULT_TX_BINARY_EN replaces the hex digit with four binary digits (sum[3] first).
module lab2_result_tx #(
  parameter logic [7:0]  PREFIX_CHAR = 8'h3D,
  parameter int unsigned EOL_LF      = 1,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic       i_clk_in,
  input  logic       i_rst,
  input  logic       i_rdy,
  input  logic [3:0] i_sum,
  input  logic       i_cout,
  input  logic       i_tx_busy,
  input  logic       i_clr_ovr,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  output logic       o_busy,
  output logic       o_overrun
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

`ifdef LAB2_RESULT_TX_BINARY_EN
  localparam logic [2:0] LAST_IDX = (EOL_LF != 0) ? 3'd7 : 3'd6;
`else
  localparam logic [2:0] LAST_IDX = (EOL_LF != 0) ? 3'd4 : 3'd3;
`endif
  localparam logic [3:0] TMO_LAST = 4'(ACK_TIMEOUT - 1);

  state_t     state, state_nx;
  logic       rdy_d;
  logic       rise;
  logic [3:0] sum_q, sum_nx;
  logic       cout_q, cout_nx;
  logic [2:0] idx, idx_nx;
  logic [3:0] cnt, cnt_nx;
  logic [7:0] tx_data_nx;
  logic       tx_start_nx;
  logic       busy_nx;
  logic       ovr_nx;
  logic       byte_done;

  function automatic logic [7:0] char_at(input logic [2:0] i, input logic [3:0] s, input logic c);
    logic [7:0] ch;
    ch = 8'h00;
`ifdef LAB2_RESULT_TX_BINARY_EN
    case (i)
      3'd0:    ch = PREFIX_CHAR;
      3'd1:    ch = {7'b0011000, c};
      3'd2:    ch = {7'b0011000, s[3]};
      3'd3:    ch = {7'b0011000, s[2]};
      3'd4:    ch = {7'b0011000, s[1]};
      3'd5:    ch = {7'b0011000, s[0]};
      3'd6:    ch = 8'h0D;
      default: ch = 8'h0A;
    endcase
`else
    case (i)
      3'd0:    ch = PREFIX_CHAR;
      3'd1:    ch = {7'b0011000, c};
      3'd2:    ch = (s < 4'd10) ? (8'h30 + {4'h0, s}) : (8'h37 + {4'h0, s});
      3'd3:    ch = 8'h0D;
      default: ch = 8'h0A;
    endcase
`endif
    return ch;
  endfunction

  assign rise = i_rdy & ~rdy_d;

  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      rdy_d      <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_nx;
      rdy_d      <= i_rdy;
      sum_q      <= sum_nx;
      cout_q     <= cout_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      o_tx_data  <= tx_data_nx;
      o_tx_start <= tx_start_nx;
      o_busy     <= busy_nx;
      o_overrun  <= ovr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    sum_nx      = sum_q;
    cout_nx     = cout_q;
    idx_nx      = idx;
    cnt_nx      = cnt;
    tx_data_nx  = o_tx_data;
    tx_start_nx = 1'b0;
    busy_nx     = o_busy;
    byte_done   = 1'b0;
    // a rise outside IDLE sets overrun even when a clear arrives in the same cycle
    ovr_nx      = (o_overrun & ~i_clr_ovr) | (rise & (state != IDLE));

    case (state)
      IDLE: begin
        if (rise) begin
          sum_nx   = i_sum;
          cout_nx  = i_cout;
          idx_nx   = '0;
          busy_nx  = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (!i_tx_busy) begin
          tx_data_nx  = char_at(idx, sum_q, cout_q);
          tx_start_nx = 1'b1;
          cnt_nx      = '0;
          state_nx    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (i_tx_busy) begin
          state_nx = WAIT_DONE;
        end else if (cnt == TMO_LAST) begin
          byte_done = 1'b1;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) byte_done = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    if (byte_done) begin
      if (idx == LAST_IDX) begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end else begin
        idx_nx   = idx + 3'd1;
        state_nx = SEND;
      end
    end
  end

endmodule
